// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory controller: funct3 codes,
// FSM state encoding and the access-size decode.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Access width in bytes; illegal codes decode as a word and are rejected elsewhere.
  function automatic logic [2:0] dmem_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: dmem_size = 3'd1;
      F3_H, F3_HU: dmem_size = 3'd2;
      default:     dmem_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
interface data_mem_ctrl_if;
  // Handshake: a request is accepted on a rising edge where REQ=1 and READY=1;
  // REQ while READY=0 is dropped, not queued. VALID pulses for one cycle per
  // accepted request; READDATA and ERR are meaningful only while VALID=1.
  logic        REQ;
  logic        WE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic        READY;
  logic        VALID;
  logic [31:0] READDATA;
  logic        ERR;

  modport master (
    output REQ, WE, FUNCT3, ADDRESS, WRITEDATA,
    input  READY, VALID, READDATA, ERR
  );

  modport slave (
    input  REQ, WE, FUNCT3, ADDRESS, WRITEDATA,
    output READY, VALID, READDATA, ERR
  );
endinterface

// File: rtl/dmem_load_align.sv
// Builds the extended load result from the four bytes at the access address
// (i_raw[7:0] is the byte at the lowest address).
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_W:    o_data = i_raw;
      F3_BU:   o_data = {24'd0, i_raw[7:0]};
      F3_HU:   o_data = {16'd0, i_raw[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32 data memory with programmable response latency; misaligned, out-of-range
// and illegal-funct3 accesses complete with ERR and leave memory untouched.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter  int DEPTH_BYTES = 1024,
  parameter  int LATENCY     = 2,
  localparam int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic            CLK,
  input  logic            RESET,
  data_mem_ctrl_if.slave  bus,
  output state_t          o_dbg_state
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [7:0]      r_mem [DEPTH_BYTES];

  // With LATENCY=1 RESP is entered on the acceptance edge, so the live bus
  // fields are used while idle and the captured copies afterwards.
  logic            w_idle;
  logic            w_we;
  logic [2:0]      w_funct3;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [2:0]      w_size;
  logic            w_legal;
  logic            w_misal;
  logic [32:0]     w_last;
  logic            w_err;
  logic            w_enter_resp;
  logic            w_commit;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_raw;
  logic [31:0]     w_load;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_we     = w_idle ? bus.WE        : r_we;
  assign w_funct3 = w_idle ? bus.FUNCT3    : r_funct3;
  assign w_addr   = w_idle ? bus.ADDRESS   : r_addr;
  assign w_wdata  = w_idle ? bus.WRITEDATA : r_wdata;

  assign w_size  = dmem_size(w_funct3);
  assign w_legal = w_we ? (w_funct3 == F3_B || w_funct3 == F3_H || w_funct3 == F3_W)
                        : (w_funct3 == F3_B || w_funct3 == F3_H || w_funct3 == F3_W ||
                           w_funct3 == F3_BU || w_funct3 == F3_HU);
  assign w_misal = ((w_size == 3'd2) && w_addr[0]) ||
                   ((w_size == 3'd4) && (w_addr[1:0] != 2'b00));
  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign w_last  = {1'b0, w_addr} + 33'(w_size) - 33'd1;
  assign w_err   = !w_legal || w_misal || (w_last >= 33'(DEPTH_BYTES));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.REQ) w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (r_cnt <= CW'(1)) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
  assign w_commit     = w_enter_resp && w_we && !w_err;

  assign w_idx = w_addr[AW-1:0];
  assign w_raw = {r_mem[w_idx + AW'(3)], r_mem[w_idx + AW'(2)],
                  r_mem[w_idx + AW'(1)], r_mem[w_idx]};

  dmem_load_align u_align (
    .i_raw    (w_raw),
    .i_funct3 (w_funct3),
    .o_data   (w_load)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_idle && bus.REQ) begin
        r_we     <= bus.WE;
        r_funct3 <= bus.FUNCT3;
        r_addr   <= bus.ADDRESS;
        r_wdata  <= bus.WRITEDATA;
        r_cnt    <= CW'(LATENCY - 1);
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_enter_resp) begin
        r_rdata <= (w_we || w_err) ? 32'd0 : w_load;
        r_err   <= w_err;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] <= 8'd0;
    end else if (w_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(w_size)) r_mem[w_idx + AW'(k)] <= w_wdata[8*k +: 8];
      end
    end
  end

  assign bus.READY    = w_idle;
  assign bus.VALID    = (r_state == ST_RESP);
  assign bus.READDATA = r_rdata;
  assign bus.ERR      = (r_state == ST_RESP) && r_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance at LATENCY=2 and one at
// LATENCY=1, exercised in turn with the same vector table and sequences.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dut_sel;
  logic        req;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  int          lat;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  data_mem_ctrl_if bus_l2();
  data_mem_ctrl_if bus_l1();
  state_t dbg_l2;
  state_t dbg_l1;

  assign bus_l2.REQ       = req & ~dut_sel;
  assign bus_l2.WE        = we;
  assign bus_l2.FUNCT3    = f3;
  assign bus_l2.ADDRESS   = addr;
  assign bus_l2.WRITEDATA = wdata;
  assign bus_l1.REQ       = req & dut_sel;
  assign bus_l1.WE        = we;
  assign bus_l1.FUNCT3    = f3;
  assign bus_l1.ADDRESS   = addr;
  assign bus_l1.WRITEDATA = wdata;

  wire        ready = dut_sel ? bus_l1.READY    : bus_l2.READY;
  wire        valid = dut_sel ? bus_l1.VALID    : bus_l2.VALID;
  wire [31:0] rdata = dut_sel ? bus_l1.READDATA : bus_l2.READDATA;
  wire        err   = dut_sel ? bus_l1.ERR      : bus_l2.ERR;

  data_mem_ctrl #(.DEPTH_BYTES(1024), .LATENCY(2)) u_lat2 (
    .CLK(clk), .RESET(rst), .bus(bus_l2), .o_dbg_state(dbg_l2)
  );
  data_mem_ctrl #(.DEPTH_BYTES(1024), .LATENCY(1)) u_lat1 (
    .CLK(clk), .RESET(rst), .bus(bus_l1), .o_dbg_state(dbg_l1)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] e, input logic ee);
    vec_t v;
    v.we = w; v.f3 = f; v.addr = a; v.wdata = d; v.exp_rd = e; v.exp_err = ee;
    vq.push_back(v);
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (lat=%0d): got %h expected %h", name, lat, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_access(input string tag, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_err);
    int   n;
    int   rlow;
    logic seen;
    @(posedge clk); #1;
    req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0; rlow = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (!ready) rlow++;
      if (valid) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, " valid_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " latency"}, 32'(n), 32'(lat));
      chk({tag, " ready_low_cycles"}, 32'(rlow), 32'(lat));
      chk({tag, " readdata"}, rdata, exp_rd);
      chk({tag, " err"}, 32'(err), 32'(exp_err));
      @(negedge clk);
      chk({tag, " ready_after"}, 32'(ready), 32'd1);
      chk({tag, " valid_after"}, 32'(valid), 32'd0);
      chk({tag, " err_after"}, 32'(err), 32'd0);
      chk({tag, " readdata_held"}, rdata, exp_rd);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset readdata", rdata, 32'd0);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) chk({tag, " unexpected_valid"}, 32'd1, 32'd0);
    else chk({tag, " readdata"}, rdata, exp_q.pop_front());
  endtask

  // REQ held high with the address toggling every cycle; only the address
  // present on a READY cycle may be served.
  task automatic stream_test();
    int acc;
    int bound;
    acc = 0;
    exp_q.delete();
    for (int i = 0; i < 4 * (lat + 1); i++) begin
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; f3 = F3_W;
      addr = (i % 2 == 0) ? 32'h10 : 32'h3FC;
      @(negedge clk);
      if (valid) pop_check("stream");
      if (ready) begin
        exp_q.push_back((addr == 32'h10) ? 32'hDEAD55EF : 32'h80013344);
        acc++;
      end
    end
    req = 1'b0;
    bound = 0;
    while (exp_q.size() > 0 && bound < 10) begin
      @(negedge clk);
      bound++;
      if (valid) pop_check("stream_drain");
    end
    chk("stream acceptances", 32'(acc), 32'd4);
    chk("stream pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic midbusy_reset_test();
    do_access("pre_sw20", 1'b1, F3_W, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; f3 = F3_W; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    #2;
    chk("midbusy ready_before_reset", 32'(ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midbusy ready_in_reset", 32'(ready), 32'd1);
    chk("midbusy valid_in_reset", 32'(valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    do_access("post_reset_lw20", 1'b0, F3_W, 32'h20, 32'd0, 32'h00000000, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'd0; addr = '0; wdata = '0;
    dut_sel = 1'b0; lat = 2;

    add(1'b1, F3_W,   32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0);
    add(1'b0, F3_W,   32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
    add(1'b0, F3_B,   32'h010, 32'h0,        32'hFFFFFFEF, 1'b0);
    add(1'b0, F3_BU,  32'h010, 32'h0,        32'h000000EF, 1'b0);
    add(1'b0, F3_H,   32'h012, 32'h0,        32'hFFFFDEAD, 1'b0);
    add(1'b0, F3_HU,  32'h012, 32'h0,        32'h0000DEAD, 1'b0);
    add(1'b1, F3_B,   32'h011, 32'hAAAAAA55, 32'h00000000, 1'b0);
    add(1'b0, F3_W,   32'h010, 32'h0,        32'hDEAD55EF, 1'b0);
    add(1'b0, F3_W,   32'h014, 32'h0,        32'h00000000, 1'b0);
    add(1'b1, F3_W,   32'h3FC, 32'h11223344, 32'h00000000, 1'b0);
    add(1'b0, F3_W,   32'h013, 32'h0,        32'h00000000, 1'b1);
    add(1'b0, F3_W,   32'h3FC, 32'h0,        32'h11223344, 1'b0);
    add(1'b1, F3_H,   32'h3FF, 32'h0000BEEF, 32'h00000000, 1'b1);
    add(1'b0, F3_W,   32'h3FC, 32'h0,        32'h11223344, 1'b0);
    add(1'b0, 3'b011, 32'h3FC, 32'h0,        32'h00000000, 1'b1);
    add(1'b0, F3_W,   32'h3FC, 32'h0,        32'h11223344, 1'b0);
    add(1'b1, 3'b100, 32'h3FC, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    add(1'b0, F3_W,   32'h3FC, 32'h0,        32'h11223344, 1'b0);
    add(1'b1, F3_B,   32'h400, 32'h000000AA, 32'h00000000, 1'b1);
    add(1'b0, F3_W,   32'hFFFFFFFC, 32'h0,   32'h00000000, 1'b1);
    add(1'b0, F3_H,   32'h011, 32'h0,        32'h00000000, 1'b1);
    add(1'b0, F3_H,   32'h3FE, 32'h0,        32'h00001122, 1'b0);
    add(1'b0, F3_B,   32'h3FF, 32'h0,        32'h00000011, 1'b0);
    add(1'b1, F3_H,   32'h3FE, 32'h00008001, 32'h00000000, 1'b0);
    add(1'b0, F3_W,   32'h3FC, 32'h0,        32'h80013344, 1'b0);
    add(1'b0, F3_H,   32'h3FE, 32'h0,        32'hFFFF8001, 1'b0);
    add(1'b0, F3_BU,  32'h3FF, 32'h0,        32'h00000080, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      dut_sel = (s == 1);
      lat = (s == 0) ? 2 : 1;
      do_reset();
      do_access("cleared_lw10", 1'b0, F3_W, 32'h10, 32'd0, 32'h00000000, 1'b0);
      for (int i = 0; i < vq.size(); i++) begin
        do_access($sformatf("vec%0d", i), vq[i].we, vq[i].f3, vq[i].addr,
                  vq[i].wdata, vq[i].exp_rd, vq[i].exp_err);
      end
      stream_test();
      if (lat > 1) midbusy_reset_test();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
